// File: rtl/ps2_key_decoder_if.sv
// Decoded keyboard outputs: held key levels, the last scancode and debug strobes.
// The decoder drives the master side. The arpeggiator and debug logic use the slave side.
interface ps2_key_decoder_if;
   logic       key0;
   logic       key1;
   logic       key2;
   logic       key3;
   logic [7:0] scancode;
   logic       code_valid;
   logic       frame_err;

   modport master (output key0, key1, key2, key3, scancode, code_valid, frame_err);
   modport slave  (input  key0, key1, key2, key3, scancode, code_valid, frame_err);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver. It filters the clock, frames bytes and checks them, then tracks F0/E0 prefixes.
// It holds one key-on level per mapped make code.
module ps2_key_decoder #(
   parameter logic [7:0]  KEY0_CODE = 8'h1C,
   parameter logic [7:0]  KEY1_CODE = 8'h1B,
   parameter logic [7:0]  KEY2_CODE = 8'h23,
   parameter logic [7:0]  KEY3_CODE = 8'h2B,
   parameter logic [15:0] TIMEOUT   = 16'd50000
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              PS2_CLK,
   input  logic              PS2_DAT,
   ps2_key_decoder_if.master kb
);

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [1:0]  r_clk_sync;
   logic [1:0]  r_dat_sync;
   logic        r_clk_filt;
   logic [1:0]  r_agree_cnt;
   logic        r_fall_strb;
   state_t      r_state;
   logic [2:0]  r_bit_cnt;
   logic [7:0]  r_shift;
   logic        r_par_ok;
   logic [15:0] r_to_cnt;
   logic        r_brk_pend;
   logic        r_ext_pend;
   logic [3:0]  r_key;
   logic [7:0]  r_scancode;
   logic        r_code_valid;
   logic        r_frame_err;

   logic        w_clk_s;
   logic        w_dat_s;
   logic [3:0]  w_key_hit;

   assign w_clk_s   = r_clk_sync[1];
   assign w_dat_s   = r_dat_sync[1];
   assign w_key_hit = {r_shift == KEY3_CODE, r_shift == KEY2_CODE,
                       r_shift == KEY1_CODE, r_shift == KEY0_CODE};

   // Synchronizers and the filter reset to the idle-high bus level. This keeps a release from reset from looking like a falling edge.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_clk_sync  <= 2'b11;
         r_dat_sync  <= 2'b11;
         r_clk_filt  <= 1'b1;
         r_agree_cnt <= 2'd0;
         r_fall_strb <= 1'b0;
      end else begin
         // NOTE: every register in a clocked block uses <=. All of them then update together from values taken before the edge.
         r_clk_sync  <= {r_clk_sync[0], PS2_CLK};
         r_dat_sync  <= {r_dat_sync[0], PS2_DAT};
         r_fall_strb <= 1'b0;
         if (w_clk_s == r_clk_filt) begin
            r_agree_cnt <= 2'd0;
         end else if (r_agree_cnt == 2'd3) begin
            r_clk_filt  <= w_clk_s;
            r_agree_cnt <= 2'd0;
            r_fall_strb <= r_clk_filt;
         end else begin
            r_agree_cnt <= r_agree_cnt + 2'd1;
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'h00;
         r_par_ok     <= 1'b0;
         r_to_cnt     <= 16'd0;
         r_brk_pend   <= 1'b0;
         r_ext_pend   <= 1'b0;
         r_key        <= 4'b0000;
         r_scancode   <= 8'h00;
         r_code_valid <= 1'b0;
         r_frame_err  <= 1'b0;
      end else begin
         r_code_valid <= 1'b0;
         r_frame_err  <= 1'b0;
         if (r_fall_strb) begin
            r_to_cnt <= 16'd0;
            unique case (r_state)
               S_IDLE: begin
                  if (!w_dat_s) begin
                     r_state   <= S_DATA;
                     r_bit_cnt <= 3'd0;
                  end
               end
               S_DATA: begin
                  r_shift   <= {w_dat_s, r_shift[7:1]};
                  r_bit_cnt <= r_bit_cnt + 3'd1;
                  if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
               end
               S_PARITY: begin
                  r_par_ok <= ^{r_shift, w_dat_s};
                  r_state  <= S_STOP;
               end
               S_STOP: begin
                  r_state <= S_IDLE;
                  if (w_dat_s && r_par_ok) begin
                     r_scancode   <= r_shift;
                     r_code_valid <= 1'b1;
                     if (r_shift == 8'hF0) begin
                        r_brk_pend <= 1'b1;
                     end else if (r_shift == 8'hE0) begin
                        r_ext_pend <= 1'b1;
                     end else begin
                        if (!r_ext_pend)
                           r_key <= (r_key & ~w_key_hit) | (w_key_hit & {4{!r_brk_pend}});
                        r_brk_pend <= 1'b0;
                        r_ext_pend <= 1'b0;
                     end
                  end else begin
                     r_frame_err <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end else if (r_state == S_IDLE) begin
            r_to_cnt <= 16'd0;
         end else if (r_to_cnt == TIMEOUT - 16'd1) begin
            // A stalled partial frame is abandoned. Prefix flags and key levels are kept.
            r_state     <= S_IDLE;
            r_to_cnt    <= 16'd0;
            r_frame_err <= 1'b1;
         end else begin
            r_to_cnt <= r_to_cnt + 16'd1;
         end
      end
   end

   assign kb.key0       = r_key[0];
   assign kb.key1       = r_key[1];
   assign kb.key2       = r_key[2];
   assign kb.key3       = r_key[3];
   assign kb.scancode   = r_scancode;
   assign kb.code_valid = r_code_valid;
   assign kb.frame_err  = r_frame_err;

endmodule
